uart_reply_tx: RTL and testbench

Transmit-side companion to the UART command controller. It accepts a reply request (command echo, status, 16-bit value) from control logic and serialises it into a fixed 6-byte packet. The packet is written into the UART TX FIFO, which feeds the UART transmitter.
- Packet byte order: SYNC, CMD, STATUS, VAL_HI, VAL_LO, CHECKSUM.
- A packet starts only when the FIFO has room for the whole packet, so packets are never split by backpressure under normal operation.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_reply_tx.sv | 130 +++++++++++++
 tb/tb_uart_reply_tx.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART reply path: packet length,
//               default sync byte, reply FSM state encoding, packet byte
//               index constants and the reply checksum helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // First byte of every reply packet unless overridden at the top level
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Bytes per reply packet: SYNC, CMD, STATUS, VAL_HI, VAL_LO, CHECKSUM
  localparam int PKT_LEN = 6;

  // Reply FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Position of each field within the packet
  localparam logic [2:0] IDX_SYNC   = 3'd0;
  localparam logic [2:0] IDX_CMD    = 3'd1;
  localparam logic [2:0] IDX_STATUS = 3'd2;
  localparam logic [2:0] IDX_VAL_HI = 3'd3;
  localparam logic [2:0] IDX_VAL_LO = 3'd4;
  localparam logic [2:0] IDX_CSUM   = 3'd5;

  // XOR over every payload byte (the sync byte is not covered)
  function automatic logic [7:0] reply_checksum(
    input logic [7:0]  cmd,
    input logic [7:0]  status,
    input logic [15:0] value
  );
    return cmd ^ status ^ value[15:8] ^ value[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_reply_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_reply_tx
// Description : Serialises a reply request (command echo, status, 16-bit
//               value) into a 6-byte packet written into the UART TX FIFO.
//               A packet is only started when the FIFO can hold all of it.
// Ports       :
//   clk, rst                 - clock, synchronous active-high reset
//   reply_valid/ready        - request handshake
//   reply_cmd/status/value   - request payload (value sent big-endian)
//   tx_fifo_data/write_enable- byte and write strobe into the TX FIFO
//   tx_fifo_full/data_count  - FIFO status used for pacing and admission
//   busy                     - packet in progress (SEND or DONE)
//   reply_done               - one-cycle pulse after the last byte
// Revision    : 1.0 - initial release
// ============================================================================
module uart_reply_tx
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int         FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reply_valid,
  output logic        reply_ready,
  input  logic [7:0]  reply_cmd,
  input  logic [7:0]  reply_status,
  input  logic [15:0] reply_value,
  output logic [7:0]  tx_fifo_data,
  output logic        tx_fifo_write_enable,
  input  logic        tx_fifo_full,
  input  logic [5:0]  tx_fifo_data_count,
  output logic        busy,
  output logic        reply_done
);

  logic [1:0]  r_state;
  logic [2:0]  r_idx;
  logic [7:0]  r_cmd;
  logic [7:0]  r_status;
  logic [15:0] r_value;
  logic [7:0]  r_csum;

  logic [6:0]  w_free;
  logic        w_space_ok;
  logic        w_ready;
  logic        w_write;
  logic [7:0]  w_byte;

  // Free space is computed one bit wider than the count so a depth of up
  // to 63 minus any count never wraps. The count bound guards against a
  // nonsensical count above the depth looking like a huge free space.
  assign w_free     = 7'(FIFO_DEPTH) - {1'b0, tx_fifo_data_count};
  assign w_space_ok = (w_free >= 7'(PKT_LEN)) &&
                      ({1'b0, tx_fifo_data_count} <= 7'(FIFO_DEPTH));

  // rst is folded in so the request side sees "not ready" while reset is
  // held, independent of the state register's pre-reset contents.
  assign w_ready = !rst && (r_state == IDLE) && !tx_fifo_full && w_space_ok;

  // A byte is written on every SEND cycle the FIFO is not full
  assign w_write = (r_state == SEND) && !tx_fifo_full;

  always_comb begin
    w_byte = 8'h00;
    if (r_state == SEND) begin
      case (r_idx)
        IDX_SYNC:   w_byte = SYNC_BYTE;
        IDX_CMD:    w_byte = r_cmd;
        IDX_STATUS: w_byte = r_status;
        IDX_VAL_HI: w_byte = r_value[15:8];
        IDX_VAL_LO: w_byte = r_value[7:0];
        IDX_CSUM:   w_byte = r_csum;
        default:    w_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= IDX_SYNC;
      r_cmd    <= 8'h00;
      r_status <= 8'h00;
      r_value  <= 16'h0000;
      r_csum   <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (reply_valid && w_ready) begin
            r_cmd    <= reply_cmd;
            r_status <= reply_status;
            r_value  <= reply_value;
            r_csum   <= reply_checksum(reply_cmd, reply_status, reply_value);
            r_idx    <= IDX_SYNC;
            r_state  <= SEND;
          end
        end
        SEND: begin
          // Backpressure simply freezes the index; the byte mux output
          // therefore holds until the FIFO drains.
          if (!tx_fifo_full) begin
            if (r_idx == IDX_CSUM) begin
              r_idx   <= IDX_SYNC;
              r_state <= DONE;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= IDX_SYNC;
        end
      endcase
    end
  end

  assign reply_ready          = w_ready;
  assign tx_fifo_write_enable = w_write;
  assign tx_fifo_data         = w_byte;
  assign busy                 = (r_state == SEND) || (r_state == DONE);
  assign reply_done           = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_uart_reply_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_reply_tx
// Description : Self-checking bench for uart_reply_tx. A table of requests
//               with hand-computed packets drives the main loop; directed
//               sequences cover space gating, backpressure, back-to-back
//               requests and reset in the middle of a packet.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_reply_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reply_valid;
  logic        reply_ready;
  logic [7:0]  reply_cmd;
  logic [7:0]  reply_status;
  logic [15:0] reply_value;
  logic [7:0]  tx_fifo_data;
  logic        tx_fifo_write_enable;
  logic        tx_fifo_full;
  logic [5:0]  tx_fifo_data_count;
  logic        busy;
  logic        reply_done;

  always #5 clk = ~clk;

  uart_reply_tx #(
    .SYNC_BYTE  (8'hA5),
    .FIFO_DEPTH (32)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .reply_valid          (reply_valid),
    .reply_ready          (reply_ready),
    .reply_cmd            (reply_cmd),
    .reply_status         (reply_status),
    .reply_value          (reply_value),
    .tx_fifo_data         (tx_fifo_data),
    .tx_fifo_write_enable (tx_fifo_write_enable),
    .tx_fifo_full         (tx_fifo_full),
    .tx_fifo_data_count   (tx_fifo_data_count),
    .busy                 (busy),
    .reply_done           (reply_done)
  );

  // Request with its expected packet, first byte in the top bits
  typedef struct packed {
    logic [7:0]  cmd;
    logic [7:0]  status;
    logic [15:0] value;
    logic [47:0] pkt;
  } vec_t;

  vec_t vecs [0:4];

  int total = 0;
  int bad   = 0;

  // Bytes the FIFO would have accepted, and count of done pulses
  logic [7:0] wr_q [$];
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_fifo_write_enable) wr_q.push_back(tx_fifo_data);
      if (reply_done) done_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic run_to_done(input string name);
    int n = 0;
    while (reply_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({name, " done reached"}, 32'(reply_done), 32'd1);
  endtask

  // exp holds up to 12 bytes, first byte in the top bits
  task automatic check_q(input string name, input logic [95:0] exp, input int n);
    chk({name, " write count"}, 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wr_q.size())
        chk($sformatf("%s byte%0d", name, i), 32'(wr_q[i]), 32'(exp[95-8*i -: 8]));
    end
  endtask

  task automatic set_req(input logic [7:0] c, input logic [7:0] s, input logic [15:0] v);
    reply_cmd    = c;
    reply_status = s;
    reply_value  = v;
  endtask

  initial begin
    int n;
    int done_before;

    // Checksums: 01^00^12^34=27, 02^FF^AB^CD=9B, 3C^5A^00^FF=99,
    // FF^FF^FF^FF=00, 80^01^02^03=80
    vecs[0] = '{8'h01, 8'h00, 16'h1234, 48'hA5_01_00_12_34_27};
    vecs[1] = '{8'h02, 8'hFF, 16'hABCD, 48'hA5_02_FF_AB_CD_9B};
    vecs[2] = '{8'h3C, 8'h5A, 16'h00FF, 48'hA5_3C_5A_00_FF_99};
    vecs[3] = '{8'hFF, 8'hFF, 16'hFFFF, 48'hA5_FF_FF_FF_FF_00};
    vecs[4] = '{8'h80, 8'h01, 16'h0203, 48'hA5_80_01_02_03_80};

    reply_valid        = 1'b0;
    tx_fifo_full       = 1'b0;
    tx_fifo_data_count = 6'd0;
    set_req(8'h00, 8'h00, 16'h0000);

    // ---------------- reset state ----------------
    rst = 1'b1;
    step();
    step();
    chk("reset we",    32'(tx_fifo_write_enable), 32'd0);
    chk("reset data",  32'(tx_fifo_data),         32'h00);
    chk("reset busy",  32'(busy),                 32'd0);
    chk("reset done",  32'(reply_done),           32'd0);
    chk("reset ready", 32'(reply_ready),          32'd0);
    rst = 1'b0;
    settle();
    chk("ready after reset", 32'(reply_ready), 32'd1);

    // ---------------- table-driven packets ----------------
    for (int v = 0; v < 5; v++) begin
      wr_q.delete();
      set_req(vecs[v].cmd, vecs[v].status, vecs[v].value);
      reply_valid = 1'b1;
      settle();
      chk($sformatf("v%0d ready", v), 32'(reply_ready), 32'd1);
      step();
      // Scramble inputs after accept; captured values must be used
      reply_valid = 1'b0;
      set_req(~vecs[v].cmd, ~vecs[v].status, ~vecs[v].value);
      settle();
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("v%0d we%0d", v, k),   32'(tx_fifo_write_enable), 32'd1);
        chk($sformatf("v%0d data%0d", v, k), 32'(tx_fifo_data), 32'(vecs[v].pkt[47-8*k -: 8]));
        chk($sformatf("v%0d busy%0d", v, k), 32'(busy), 32'd1);
        step();
      end
      chk($sformatf("v%0d done", v),     32'(reply_done),           32'd1);
      chk($sformatf("v%0d done we", v),  32'(tx_fifo_write_enable), 32'd0);
      chk($sformatf("v%0d done busy", v),32'(busy),                 32'd1);
      step();
      chk($sformatf("v%0d done clear", v), 32'(reply_done), 32'd0);
      chk($sformatf("v%0d idle busy", v),  32'(busy),       32'd0);
    end

    // ---------------- space gating ----------------
    wr_q.delete();
    tx_fifo_data_count = 6'd27;
    set_req(vecs[2].cmd, vecs[2].status, vecs[2].value);
    reply_valid = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) begin
      chk("gate ready low", 32'(reply_ready),          32'd0);
      chk("gate no write",  32'(tx_fifo_write_enable), 32'd0);
      chk("gate not busy",  32'(busy),                 32'd0);
      step();
    end
    chk("gate queue empty", 32'(wr_q.size()), 32'd0);
    tx_fifo_data_count = 6'd26;
    settle();
    chk("gate ready at 26", 32'(reply_ready), 32'd1);
    step();
    reply_valid        = 1'b0;
    tx_fifo_data_count = 6'd0;
    settle();
    chk("gate accepted busy", 32'(busy),         32'd1);
    chk("gate first byte",    32'(tx_fifo_data), 32'hA5);
    run_to_done("gate");
    check_q("gate pkt", {vecs[2].pkt, 48'h0}, 6);
    step();

    // ---------------- mid-packet backpressure ----------------
    wr_q.delete();
    set_req(vecs[0].cmd, vecs[0].status, vecs[0].value);
    reply_valid = 1'b1;
    settle();
    step();
    reply_valid = 1'b0;
    settle();
    step();
    step();
    step();
    // bytes 0..2 written; hold off byte 3
    tx_fifo_full = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("bp no write",  32'(tx_fifo_write_enable), 32'd0);
      chk("bp data hold", 32'(tx_fifo_data),         32'h12);
      chk("bp busy",      32'(busy),                 32'd1);
      step();
    end
    tx_fifo_full = 1'b0;
    settle();
    chk("bp release we",   32'(tx_fifo_write_enable), 32'd1);
    chk("bp release data", 32'(tx_fifo_data),         32'h12);
    step();
    chk("bp data lo", 32'(tx_fifo_data), 32'h34);
    step();
    chk("bp csum",    32'(tx_fifo_data), 32'h27);
    step();
    chk("bp done", 32'(reply_done), 32'd1);
    check_q("bp pkt", {vecs[0].pkt, 48'h0}, 6);
    step();

    // ---------------- back-to-back requests ----------------
    wr_q.delete();
    set_req(vecs[0].cmd, vecs[0].status, vecs[0].value);
    reply_valid = 1'b1;
    settle();
    step();
    set_req(vecs[1].cmd, vecs[1].status, vecs[1].value);
    settle();
    n = 0;
    while (reply_done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("b2b cycles to done", 32'(n), 32'd6);
    step();
    chk("b2b idle ready", 32'(reply_ready), 32'd1);
    chk("b2b idle busy",  32'(busy),        32'd0);
    step();
    reply_valid = 1'b0;
    settle();
    chk("b2b second accepted", 32'(busy),         32'd1);
    chk("b2b second sync",     32'(tx_fifo_data), 32'hA5);
    run_to_done("b2b");
    check_q("b2b pkts", {vecs[0].pkt, vecs[1].pkt}, 12);
    step();

    // ---------------- reset mid-packet ----------------
    wr_q.delete();
    done_before = done_cnt;
    set_req(vecs[4].cmd, vecs[4].status, vecs[4].value);
    reply_valid = 1'b1;
    settle();
    step();
    reply_valid = 1'b0;
    settle();
    step();
    step();
    step();
    step();
    // bytes 0..3 written; reset while byte 4 is presented
    rst = 1'b1;
    settle();
    step();
    chk("rst we",   32'(tx_fifo_write_enable), 32'd0);
    chk("rst busy", 32'(busy),                 32'd0);
    chk("rst done", 32'(reply_done),           32'd0);
    chk("rst data", 32'(tx_fifo_data),         32'h00);
    rst = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("post-rst no write", 32'(tx_fifo_write_enable), 32'd0);
      chk("post-rst no done",  32'(reply_done),           32'd0);
      step();
    end
    check_q("rst partial", {vecs[4].pkt[47:16], 64'h0}, 4);
    chk("rst no done pulse", 32'(done_cnt), 32'(done_before));

    wr_q.delete();
    set_req(vecs[3].cmd, vecs[3].status, vecs[3].value);
    reply_valid = 1'b1;
    settle();
    chk("post-rst ready", 32'(reply_ready), 32'd1);
    step();
    reply_valid = 1'b0;
    settle();
    run_to_done("post-rst");
    check_q("post-rst pkt", {vecs[3].pkt, 48'h0}, 6);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
